// File: rtl/dlmon_pkg.sv
// Shared types and helpers for the dataflow deadlock watchdog.
package dlmon_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WATCH  = 2'd1,
    LOCKED = 2'd2
  } dlmon_state_e;

  localparam int unsigned EVT_CNT_W = 8;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [31:0] lowest_set_idx(input logic [31:0] vec);
    logic [31:0] idx;
    logic        found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (vec[i] && !found) begin
        idx   = i;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/dlmon_prio_enc.sv
// Lowest-index priority encoder over the per-process blocked flags.
module dlmon_prio_enc
  import dlmon_pkg::*;
#(
  parameter int unsigned N_INST = 5,
  parameter int unsigned ID_W   = 5
) (
  input  logic [N_INST-1:0] i_vec,
  output logic [ID_W-1:0]   o_idx
);

  logic [31:0] w_vec;

  always_comb begin
    w_vec             = '0;
    w_vec[N_INST-1:0] = i_vec;
  end

  assign o_idx = ID_W'(lowest_set_idx(w_vec));

endmodule

// File: rtl/deadlock_watchdog_monitor.sv
// Qualifies a whole-region stall over a programmable window and latches a
// sticky deadlock status plus an input snapshot for debug readout.
module deadlock_watchdog_monitor
  import dlmon_pkg::*;
#(
  parameter  int unsigned N_INST = 5,
  parameter  int unsigned N_AXIS = 2,
  parameter  int unsigned TMO_W  = 16,
  parameter  int unsigned ID_W   = 5,
  localparam int unsigned AXIS_W = (N_AXIS == 0) ? 1 : N_AXIS
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic                 enable,
  input  logic                 clear,
  input  logic [TMO_W-1:0]     timeout_cfg,
  input  logic [N_INST-1:0]    inst_idle,
  input  logic [N_INST-1:0]    inst_block,
  input  logic [AXIS_W-1:0]    axis_block,
  output logic                 kernel_block,
  output logic [TMO_W-1:0]     stall_cnt,
  output logic                 deadlock,
  output logic                 deadlock_evt,
  output logic [ID_W-1:0]      first_block_id,
  output logic [N_INST-1:0]    snap_inst,
  output logic [AXIS_W-1:0]    snap_axis,
  output logic [EVT_CNT_W-1:0] event_cnt
);

  dlmon_state_e         r_state;
  logic                 r_kb;
  logic [TMO_W-1:0]     r_cnt;
  logic                 r_dl;
  logic                 r_evt;
  logic [ID_W-1:0]      r_fid;
  logic [N_INST-1:0]    r_snap_i;
  logic [AXIS_W-1:0]    r_snap_a;
  logic [EVT_CNT_W-1:0] r_ecnt;

  logic [AXIS_W-1:0]    w_axis;
  logic                 w_cond;
  logic [TMO_W-1:0]     w_tmo;
  logic [ID_W-1:0]      w_fid;

  // With no AXIS ports the tied-off input must never contribute.
  assign w_axis = (N_AXIS == 0) ? '0 : axis_block;
  assign w_cond = (&(inst_idle | inst_block)) & ((|inst_block) | (|w_axis));
  assign w_tmo  = (timeout_cfg == '0) ? TMO_W'(1) : timeout_cfg;

  dlmon_prio_enc #(
    .N_INST (N_INST),
    .ID_W   (ID_W)
  ) u_prio_enc (
    .i_vec (inst_block),
    .o_idx (w_fid)
  );

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state  <= IDLE;
      r_kb     <= 1'b0;
      r_cnt    <= '0;
      r_dl     <= 1'b0;
      r_evt    <= 1'b0;
      r_fid    <= '0;
      r_snap_i <= '0;
      r_snap_a <= '0;
      r_ecnt   <= '0;
    end else begin
      r_kb  <= w_cond;
      r_evt <= 1'b0;
      if (clear) begin
        r_state  <= IDLE;
        r_cnt    <= '0;
        r_dl     <= 1'b0;
        r_fid    <= '0;
        r_snap_i <= '0;
        r_snap_a <= '0;
      end else if (!enable) begin
        // A declared deadlock survives disarming; only clear releases it.
        if (r_state != LOCKED) begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      end else begin
        case (r_state)
          IDLE: begin
            if (w_cond) begin
              r_state <= WATCH;
              r_cnt   <= TMO_W'(1);
              r_fid   <= w_fid;
            end
          end
          WATCH: begin
            if (!w_cond) begin
              r_state <= IDLE;
              r_cnt   <= '0;
            end else if (r_cnt >= w_tmo) begin
              r_state  <= LOCKED;
              r_dl     <= 1'b1;
              r_evt    <= 1'b1;
              r_snap_i <= inst_block;
              r_snap_a <= w_axis;
              if (r_ecnt != '1) r_ecnt <= r_ecnt + 1'b1;
            end else if (r_cnt != '1) begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          LOCKED: begin
            r_state <= LOCKED;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign kernel_block   = r_kb;
  assign stall_cnt      = r_cnt;
  assign deadlock       = r_dl;
  assign deadlock_evt   = r_evt;
  assign first_block_id = r_fid;
  assign snap_inst      = r_snap_i;
  assign snap_axis      = r_snap_a;
  assign event_cnt      = r_ecnt;

endmodule

// File: tb/tb_deadlock_watchdog_monitor.sv
// Directed scoreboard bench for deadlock_watchdog_monitor.
module tb_deadlock_watchdog_monitor;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        enable;
  logic        clear;
  logic [15:0] timeout_cfg;
  logic [4:0]  inst_idle;
  logic [4:0]  inst_block;
  logic [1:0]  axis_block;
  logic        kernel_block;
  logic [15:0] stall_cnt;
  logic        deadlock;
  logic        deadlock_evt;
  logic [4:0]  first_block_id;
  logic [4:0]  snap_inst;
  logic [1:0]  snap_axis;
  logic [7:0]  event_cnt;

  typedef struct {
    string      tag;
    int         lat;
    logic [4:0] fid;
    logic [4:0] si;
    logic [1:0] sa;
    logic [7:0] ec;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   exp_ec   = 0;

  always #5 ap_clk = ~ap_clk;

  deadlock_watchdog_monitor #(
    .N_INST (5),
    .N_AXIS (2),
    .TMO_W  (16),
    .ID_W   (5)
  ) dut (
    .ap_clk         (ap_clk),
    .ap_rst_n       (ap_rst_n),
    .enable         (enable),
    .clear          (clear),
    .timeout_cfg    (timeout_cfg),
    .inst_idle      (inst_idle),
    .inst_block     (inst_block),
    .axis_block     (axis_block),
    .kernel_block   (kernel_block),
    .stall_cnt      (stall_cnt),
    .deadlock       (deadlock),
    .deadlock_evt   (deadlock_evt),
    .first_block_id (first_block_id),
    .snap_inst      (snap_inst),
    .snap_axis      (snap_axis),
    .event_cnt      (event_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_kb"},   kernel_block,   0);
    chk({tag, "_cnt"},  stall_cnt,      0);
    chk({tag, "_dl"},   deadlock,       0);
    chk({tag, "_evt"},  deadlock_evt,   0);
    chk({tag, "_fid"},  first_block_id, 0);
    chk({tag, "_si"},   snap_inst,      0);
    chk({tag, "_sa"},   snap_axis,      0);
    chk({tag, "_ecnt"}, event_cnt,      0);
  endtask

  // lat counts clock edges from the call until deadlock_evt is visible.
  task automatic expect_decl(input string tag, input int lat, input logic [4:0] fid,
                             input logic [4:0] si, input logic [1:0] sa);
    exp_t e;
    if (exp_ec < 255) exp_ec++;
    e.tag = tag; e.lat = lat; e.fid = fid; e.si = si; e.sa = sa; e.ec = 8'(exp_ec);
    sb.push_back(e);
  endtask

  task automatic run_to_evt();
    exp_t e;
    int   n;
    bit   seen;
    e    = sb.pop_front();
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      step();
      n++;
      if (n == 1) chk({e.tag, "_kb"}, kernel_block, 1);
      if (deadlock_evt === 1'b1) seen = 1'b1;
    end
    chk({e.tag, "_seen"}, 32'(seen), 1);
    chk({e.tag, "_lat"},  n,              e.lat);
    chk({e.tag, "_dl"},   deadlock,       1);
    chk({e.tag, "_fid"},  first_block_id, e.fid);
    chk({e.tag, "_si"},   snap_inst,      e.si);
    chk({e.tag, "_sa"},   snap_axis,      e.sa);
    chk({e.tag, "_ecnt"}, event_cnt,      e.ec);
    step();
    chk({e.tag, "_pulse"}, deadlock_evt, 0);
    chk({e.tag, "_hold"},  deadlock,     1);
  endtask

  initial begin
    ap_rst_n    = 1'b0;
    enable      = 1'b0;
    clear       = 1'b0;
    timeout_cfg = 16'd8;
    inst_idle   = 5'b11111;
    inst_block  = 5'b00000;
    axis_block  = 2'b00;
    #12;
    check_zero("reset");
    step();
    ap_rst_n = 1'b1;
    enable   = 1'b1;

    // Finished kernel: all idle, nothing blocked.
    repeat (100) begin
      step();
      chk("idle_kb", kernel_block, 0);
      chk("idle_dl", deadlock, 0);
    end

    // Full stall, timeout 8.
    inst_idle  = 5'b10101;
    inst_block = 5'b01010;
    expect_decl("stall8", 9, 5'd1, 5'b01010, 2'b00);
    run_to_evt();
    chk("locked_cnt", stall_cnt, 8);
    inst_idle  = 5'b11111;
    inst_block = 5'b00000;
    repeat (3) begin
      step();
      chk("locked_dl",  deadlock,     1);
      chk("locked_cnt", stall_cnt,    8);
      chk("locked_si",  snap_inst,    5'b01010);
      chk("locked_evt", deadlock_evt, 0);
    end
    chk("released_kb", kernel_block, 0);
    pulse_clear();
    chk("clr_dl",   deadlock,       0);
    chk("clr_cnt",  stall_cnt,      0);
    chk("clr_si",   snap_inst,      0);
    chk("clr_fid",  first_block_id, 0);
    chk("clr_ecnt", event_cnt,      1);

    // Stall released at stall_cnt=5, then counted anew.
    inst_idle  = 5'b10101;
    inst_block = 5'b01010;
    repeat (5) begin
      step();
      chk("partial_evt", deadlock_evt, 0);
    end
    chk("partial_cnt", stall_cnt, 5);
    inst_idle  = 5'b11111;
    inst_block = 5'b00000;
    step();
    chk("release_cnt", stall_cnt,    0);
    chk("release_dl",  deadlock,     0);
    chk("release_evt", deadlock_evt, 0);
    inst_idle  = 5'b10101;
    inst_block = 5'b01010;
    expect_decl("restall", 9, 5'd1, 5'b01010, 2'b00);
    run_to_evt();
    inst_idle  = 5'b11111;
    inst_block = 5'b00000;
    pulse_clear();

    // Lowering timeout below the running count declares on the next edge.
    inst_idle  = 5'b10101;
    inst_block = 5'b01010;
    repeat (5) step();
    chk("lower_cnt", stall_cnt, 5);
    timeout_cfg = 16'd3;
    expect_decl("tmo_lower", 1, 5'd1, 5'b01010, 2'b00);
    run_to_evt();
    timeout_cfg = 16'd8;
    inst_idle   = 5'b11111;
    inst_block  = 5'b00000;
    pulse_clear();

    // AXIS-only block with timeout 0.
    timeout_cfg = 16'd0;
    axis_block  = 2'b10;
    expect_decl("axis_only", 2, 5'd0, 5'b00000, 2'b10);
    run_to_evt();

    // Clear coincident with an ongoing stall.
    timeout_cfg = 16'd8;
    pulse_clear();
    chk("cclr_dl",   deadlock,       0);
    chk("cclr_si",   snap_inst,      0);
    chk("cclr_sa",   snap_axis,      0);
    chk("cclr_fid",  first_block_id, 0);
    chk("cclr_cnt",  stall_cnt,      0);
    chk("cclr_ecnt", event_cnt,      8'(exp_ec));
    expect_decl("redeclare", 9, 5'd0, 5'b00000, 2'b10);
    run_to_evt();

    // Asynchronous reset while watching.
    pulse_clear();
    repeat (3) step();
    chk("watch_cnt", stall_cnt, 3);
    #2;
    ap_rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    exp_ec = 0;
    step();
    ap_rst_n = 1'b1;

    // 256 declarations saturate event_cnt.
    timeout_cfg = 16'd0;
    for (int i = 0; i < 256; i++) begin
      expect_decl("sat", 2, 5'd0, 5'b00000, 2'b10);
      run_to_evt();
      pulse_clear();
    end
    chk("ecnt_sat", event_cnt, 255);
    chk("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
